sprite_pixel_pipe: RTL and testbench
====================================

Name: sprite_pixel_pipe

Overview:
- Downstream consumer of the sprite address transformer (addr/valid per screen pixel).
- Issues the sprite ROM read and waits out the ROM latency.
- Applies colour-key transparency and composites the sprite over the lower-layer background pixel.
- Delays hsync/vsync/active so the composed RGB leaves aligned with sync.
- Output drives the VGA output register stage or the next sprite layer.

Parameters:
- AWIDTH, 14, sprite ROM address width; matches the transformer's addr width.
- CWIDTH, 12, pixel colour width (4:4:4 RGB).
- ROM_LATENCY, 1, sprite ROM read latency in clocks (≥1); rom_addr registered to rom_data valid.
- TRANSPARENT, 12'hF0F, colour-key value that is treated as "no sprite pixel".
- SYNC_IDLE, 1, inactive level of hsync/vsync; also their reset value.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, synchronous active-low reset.
- addr_in, in, AWIDTH, sprite ROM address from the transformer.
- valid_in, in, 1, pixel lies inside the sprite box.
- hsync_in, in, 1, horizontal sync, same cycle as addr_in.
- vsync_in, in, 1, vertical sync, same cycle as addr_in.
- active_in, in, 1, visible-area flag, same cycle as addr_in.
- bg_rgb, in, CWIDTH, background or lower-layer pixel, same cycle as addr_in.
- rom_addr, out, AWIDTH, registered ROM address.
- rom_data, in, CWIDTH, ROM read data, ROM_LATENCY clocks after rom_addr.
- rgb, out, CWIDTH, composed pixel.
- hsync, out, 1, delayed hsync.
- vsync, out, 1, delayed vsync.
- active, out, 1, delayed active.
- hit, out, 1, opaque sprite pixel present in this output pixel.
- hit_count, out, 20, opaque-pixel count of the last frame (see Optional Feature).

Behaviour:
- Single clock domain. Every register is cleared on the rising clk edge while rst_n=0.
- Total latency LAT = ROM_LATENCY+2 clocks, fixed.
  - Cycle 0: inputs sampled.
  - Cycle 1: rom_addr valid.
  - Cycle 1+ROM_LATENCY: rom_data valid.
  - Cycle LAT: rgb, hit, hsync, vsync and active registered outputs.
- The pipeline advances every clock. There is no stall and no backpressure.
- rom_addr <= valid_in ? addr_in : 0. The zero address when outside the sprite keeps the ROM quiet; the data returned is ignored.
- Sideband delay line:
  - valid, hsync, vsync and active are each delayed LAT-1 clocks to align with rom_data.
  - bg_rgb is delayed LAT-1 clocks the same way.
  - The output register then adds the final clock.
- Compose, evaluated at the output register from the aligned stage, in priority order:
  1. active_d=0: rgb=0, hit=0. Blanking always outputs black.
  2. valid_d=1 and rom_data!=TRANSPARENT: rgb=rom_data, hit=1.
  3. Otherwise: rgb=bg_d, hit=0.
- Transparency compare is an exact full-width CWIDTH match.
- Reset values:
  - rgb=0, hit=0, active=0, rom_addr=0.
  - hsync=vsync=SYNC_IDLE.
  - All delay-line stages are cleared to the same values, valid_d=0, bg_d=0.
- Reset mid-frame:
  - All in-flight pixels are discarded.
  - Outputs hold their reset values for LAT clocks after rst_n returns high.
  - After that, outputs reflect inputs with exact LAT alignment.
- Back-to-back valid toggling (sprite edge): each pixel is handled independently with no smear between adjacent pixels.
- No internal state machine other than the optional counter. The block is a pure fixed-latency pipeline.

Optional Feature:
- Macro: SPRITE_PIPE_HIT_COUNT_EN.
- When defined:
  - A 20-bit counter increments on each output cycle with hit=1. It saturates at 2^20-1.
  - On the output-side vsync transition from SYNC_IDLE to active, hit_count <= counter (or counter+1 if hit=1 that same cycle), and the counter clears to 0.
  - hit_count is cleared by reset.
  - Used for sprite-collision / coin-pickup detection.
- When undefined: no counter logic; hit_count is tied to 0.

Test Plan:
- Reset with ROM_LATENCY=1 (LAT=3), then hold rst_n=0 for 5 clocks -> rgb=0, hit=0, active=0, hsync=vsync=1, rom_addr=0; after release, first valid output at release+3.
- active_in=1, valid_in=1, addr_in=0x0123, ROM returns 12'h0F0 -> rom_addr=0x0123 one clock later; rgb=0x0F0 and hit=1 exactly 3 clocks after input.
- Same, but ROM returns 12'hF0F with bg_rgb=12'h123 -> rgb=0x123, hit=0 at LAT.
- valid_in=1, active_in=0, ROM data 12'hFFF -> rgb=0, hit=0. Separately, valid_in=0 -> rom_addr=0 and rgb=bg.
- Pulse hsync_in low for 96 clocks alongside random pixel data -> hsync low for exactly 96 clocks, starting LAT clocks later, aligned with the rgb stream. Assert rst_n=0 mid-pulse -> hsync returns to 1 immediately, with no stale pixels afterwards.
- With SPRITE_PIPE_HIT_COUNT_EN: a frame of 7 opaque pixels, then vsync asserted -> hit_count=7 and counter clears; next frame of 0 hits -> hit_count=0. Without the macro, hit_count stays 0.

Source files
------------

// File: rtl/sprite_pixel_pipe.sv
// sprite_pixel_pipe
//   Fixed-latency sprite compositing stage. Registers the sprite ROM address,
//   waits out the ROM read latency, applies colour-key transparency and
//   composites the sprite pixel over the lower-layer background pixel. The
//   sync/active sideband is delayed so that the composed RGB leaves aligned
//   with it. Total latency LAT = ROM_LATENCY + 2 clocks, no stalls.
//
// Ports:
//   clk, rst_n        pixel clock, synchronous active-low reset
//   addr_in, valid_in sprite ROM address and in-sprite-box flag
//   hsync_in, vsync_in, active_in, bg_rgb  sideband aligned with addr_in
//   rom_addr / rom_data  sprite ROM read port (data ROM_LATENCY clocks later)
//   rgb, hsync, vsync, active, hit  registered composed outputs
//   hit_count         opaque-pixel count of the previous frame
//
// Optional feature macro: SPRITE_PIPE_HIT_COUNT_EN
//   Defined: per-frame saturating 20-bit opaque-pixel counter, latched into
//   hit_count at the start of each output vsync pulse.
//   Undefined: hit_count is tied to zero.
module sprite_pixel_pipe #(
  parameter int               AWIDTH      = 14,
  parameter int               CWIDTH      = 12,
  parameter int               ROM_LATENCY = 1,
  parameter logic [CWIDTH-1:0] TRANSPARENT = 12'hF0F,
  parameter logic             SYNC_IDLE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic              valid_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              active_in,
  input  logic [CWIDTH-1:0] bg_rgb,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [CWIDTH-1:0] rom_data,
  output logic [CWIDTH-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              hit,
  output logic [19:0]       hit_count
);

  // Sideband stages needed to line up with rom_data (LAT-1).
  localparam int DLY = ROM_LATENCY + 1;

  logic [AWIDTH-1:0]          rom_addr_q, rom_addr_d;
  logic [DLY-1:0]             valid_pipe_q, valid_pipe_d;
  logic [DLY-1:0]             hs_pipe_q, hs_pipe_d;
  logic [DLY-1:0]             vs_pipe_q, vs_pipe_d;
  logic [DLY-1:0]             act_pipe_q, act_pipe_d;
  logic [DLY-1:0][CWIDTH-1:0] bg_pipe_q, bg_pipe_d;
  logic [CWIDTH-1:0]          rgb_q, rgb_d;
  logic                       hsync_q, hsync_d;
  logic                       vsync_q, vsync_d;
  logic                       active_q, active_d;
  logic                       hit_q, hit_d;

  // Next-state for the address register, sideband delay line and compose.
  always_comb begin
    // Zero address outside the sprite keeps the ROM quiet; its data is ignored.
    rom_addr_d   = valid_in ? addr_in : {AWIDTH{1'b0}};
    valid_pipe_d = {valid_pipe_q[DLY-2:0], valid_in};
    hs_pipe_d    = {hs_pipe_q[DLY-2:0], hsync_in};
    vs_pipe_d    = {vs_pipe_q[DLY-2:0], vsync_in};
    act_pipe_d   = {act_pipe_q[DLY-2:0], active_in};
    bg_pipe_d    = {bg_pipe_q[DLY-2:0], bg_rgb};

    hsync_d  = hs_pipe_q[DLY-1];
    vsync_d  = vs_pipe_q[DLY-1];
    active_d = act_pipe_q[DLY-1];

    // Blanking wins over everything, then an opaque sprite pixel, then background.
    if (!act_pipe_q[DLY-1]) begin
      rgb_d = {CWIDTH{1'b0}};
      hit_d = 1'b0;
    end else if (valid_pipe_q[DLY-1] && (rom_data != TRANSPARENT)) begin
      rgb_d = rom_data;
      hit_d = 1'b1;
    end else begin
      rgb_d = bg_pipe_q[DLY-1];
      hit_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards every in-flight pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_q   <= {AWIDTH{1'b0}};
      valid_pipe_q <= {DLY{1'b0}};
      hs_pipe_q    <= {DLY{SYNC_IDLE}};
      vs_pipe_q    <= {DLY{SYNC_IDLE}};
      act_pipe_q   <= {DLY{1'b0}};
      bg_pipe_q    <= {DLY{{CWIDTH{1'b0}}}};
      rgb_q        <= {CWIDTH{1'b0}};
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      active_q     <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      valid_pipe_q <= valid_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      act_pipe_q   <= act_pipe_d;
      bg_pipe_q    <= bg_pipe_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      hit_q        <= hit_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rgb      = rgb_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign active   = active_q;
  assign hit      = hit_q;

`ifdef SPRITE_PIPE_HIT_COUNT_EN
  logic [19:0] hit_cnt_q, hit_cnt_d;
  logic [19:0] hit_count_q, hit_count_d;
  logic        frame_start_s;

  // Saturating increment: the count sticks at all-ones.
  function automatic logic [19:0] sat_inc(input logic [19:0] v, input logic inc);
    if (inc && (v != 20'hFFFFF)) begin
      return v + 20'd1;
    end else begin
      return v;
    end
  endfunction

  // Frame counter; a hit on the frame-start cycle still belongs to the old frame.
  always_comb begin
    frame_start_s = (vsync_q == SYNC_IDLE) && (vsync_d != SYNC_IDLE);
    if (frame_start_s) begin
      hit_count_d = sat_inc(hit_cnt_q, hit_d);
      hit_cnt_d   = 20'd0;
    end else begin
      hit_count_d = hit_count_q;
      hit_cnt_d   = sat_inc(hit_cnt_q, hit_d);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q   <= 20'd0;
      hit_count_q <= 20'd0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;
`else
  assign hit_count = 20'd0;
`endif

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Self-checking bench for sprite_pixel_pipe (AWIDTH=14, CWIDTH=12,
// ROM_LATENCY=1 so LAT=3). A history of sampled inputs drives a reference
// model: the output after clock n is the compose of the inputs sampled at
// clock n-2 (data from the ROM model), unless reset was seen in the last
// three clocks. Directed literal checks pin the model.
module tb_sprite_pixel_pipe;
  localparam int AW   = 14;
  localparam int CW   = 12;
  localparam int MAXC = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr_in;
  logic          valid_in, hsync_in, vsync_in, active_in;
  logic [CW-1:0] bg_rgb;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_data;
  logic [CW-1:0] rgb;
  logic          hsync, vsync, active, hit;
  logic [19:0]   hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_pixel_pipe #(
    .AWIDTH(14), .CWIDTH(12), .ROM_LATENCY(1),
    .TRANSPARENT(12'hF0F), .SYNC_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .valid_in(valid_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .active(active), .hit(hit),
    .hit_count(hit_count)
  );

  // Sprite ROM with one clock of read latency.
  logic [CW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic          h_rst [MAXC];
  logic          h_val [MAXC];
  logic [AW-1:0] h_addr[MAXC];
  logic          h_hs  [MAXC];
  logic          h_vs  [MAXC];
  logic          h_act [MAXC];
  logic [CW-1:0] h_bg  [MAXC];

  int            ncyc = 0;
  logic          model_ok = 1'b0;
  logic [CW-1:0] e_rgb;
  logic          e_hit, e_hs, e_vs, e_act, e_vs_prev = 1'b1;
  logic [AW-1:0] e_addr;
  logic [19:0]   e_hc = 20'd0;
  int            frame_hits = 0;

  always @(posedge clk) begin
    int n, k;
    logic in_rst;
    logic [CW-1:0] d;
    n = ncyc;
    if (n < MAXC) begin
      h_rst[n] = rst_n;   h_val[n] = valid_in; h_addr[n] = addr_in;
      h_hs[n]  = hsync_in; h_vs[n] = vsync_in; h_act[n] = active_in;
      h_bg[n]  = bg_rgb;
      in_rst = (n < 2) || !h_rst[n] || !h_rst[n-1] || !h_rst[n-2];
      if (in_rst) begin
        e_rgb = 12'h000; e_hit = 1'b0; e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        k = n - 2;
        e_hs = h_hs[k]; e_vs = h_vs[k]; e_act = h_act[k];
        d = rom_mem[h_val[k] ? h_addr[k] : 14'h0000];
        if (!h_act[k]) begin
          e_rgb = 12'h000; e_hit = 1'b0;
        end else if (h_val[k] && d != 12'hF0F) begin
          e_rgb = d; e_hit = 1'b1;
        end else begin
          e_rgb = h_bg[k]; e_hit = 1'b0;
        end
      end
      e_addr = !h_rst[n] ? 14'h0000 : (h_val[n] ? h_addr[n] : 14'h0000);
`ifdef SPRITE_PIPE_HIT_COUNT_EN
      if (!h_rst[n]) begin
        frame_hits = 0;
        e_hc = 20'd0;
      end else if (e_vs_prev && !e_vs) begin
        e_hc = 20'(frame_hits + int'(e_hit));
        frame_hits = 0;
      end else begin
        frame_hits = frame_hits + int'(e_hit);
      end
`else
      e_hc = 20'd0;
`endif
      e_vs_prev = e_vs;
      model_ok = 1'b1;
    end else begin
      model_ok = 1'b0;
    end
    ncyc = ncyc + 1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_rgb", 32'(rgb), 32'(e_rgb));
      chk("m_hit", 32'(hit), 32'(e_hit));
      chk("m_hsync", 32'(hsync), 32'(e_hs));
      chk("m_vsync", 32'(vsync), 32'(e_vs));
      chk("m_active", 32'(active), 32'(e_act));
      chk("m_rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("m_hit_count", 32'(hit_count), 32'(e_hc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic act,
                       input logic hs, input logic vs, input logic [CW-1:0] bg);
    valid_in = v; addr_in = a; active_in = act;
    hsync_in = hs; vsync_in = vs; bg_rgb = bg;
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int lows;
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      a = AW'(i);
      rom_mem[i] = a[CW-1:0] ^ 12'h5A5;
    end
    rom_mem[14'h0123] = 12'h0F0;
    rom_mem[14'h0124] = 12'hF0F;
    rom_mem[14'h0200] = 12'hFFF;

    rst_n = 1'b0;
    drive(1'b0, 14'h0000, 1'b0, 1'b1, 1'b1, 12'h000);
    tick(5);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);

    // Release with the first pixel on the same clock.
    rst_n = 1'b1;
    drive(1'b1, 14'h0123, 1'b1, 1'b1, 1'b1, 12'h555);
    tick(1);
    chk("rom_addr_opaque", 32'(rom_addr), 32'h0123);
    chk("hold_active", 32'(active), 32'h0);
    drive(1'b1, 14'h0124, 1'b1, 1'b1, 1'b1, 12'h123);
    tick(1);
    chk("hold_rgb", 32'(rgb), 32'h0);
    drive(1'b1, 14'h0200, 1'b0, 1'b1, 1'b1, 12'h777);
    tick(1);
    chk("opaque_rgb", 32'(rgb), 32'h0F0);
    chk("opaque_hit", 32'(hit), 32'h1);
    drive(1'b0, 14'h0300, 1'b1, 1'b1, 1'b1, 12'hABC);
    tick(1);
    chk("transp_rgb", 32'(rgb), 32'h123);
    chk("transp_hit", 32'(hit), 32'h0);
    chk("novalid_rom_addr", 32'(rom_addr), 32'h0);
    drive(1'b0, 14'h0000, 1'b0, 1'b1, 1'b1, 12'h000);
    tick(1);
    chk("blank_rgb", 32'(rgb), 32'h0);
    chk("blank_hit", 32'(hit), 32'h0);
    tick(1);
    chk("novalid_rgb", 32'(rgb), 32'hABC);

    // Sprite edge: valid toggles every pixel.
    for (int i = 0; i < 8; i++) begin
      drive(i[0], 14'h0123, 1'b1, 1'b1, 1'b1, 12'h321);
      tick(1);
    end

    // 96-clock hsync pulse with random pixels.
    lows = 0;
    for (int i = 0; i < 116; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 16383)), 1'b1,
            (i >= 5 && i < 101) ? 1'b0 : 1'b1, 1'b1, CW'($urandom));
      tick(1);
      if (hsync == 1'b0) lows++;
    end
    chk("hsync_low_count", 32'(lows), 32'd96);

    // Reset in the middle of a pulse.
    for (int i = 0; i < 60; i++) begin
      if (i == 30) rst_n = 1'b0;
      if (i == 33) rst_n = 1'b1;
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 16383)), 1'b1,
            (i >= 5) ? 1'b0 : 1'b1, 1'b1, CW'($urandom));
      tick(1);
      if (i == 30) chk("rst_hsync_immediate", 32'(hsync), 32'h1);
      if (i == 33 || i == 34) begin
        chk("post_rst_active", 32'(active), 32'h0);
        chk("post_rst_rgb", 32'(rgb), 32'h0);
      end
    end

    // Frames for the hit counter: sync frame, 7 hits, then 0 hits.
    drive(1'b0, 14'h0000, 1'b0, 1'b1, 1'b1, 12'h000);
    tick(3);
    for (int f = 0; f < 3; f++) begin
      drive(1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 12'h000);
      tick(3);
      if (f == 1) begin
`ifdef SPRITE_PIPE_HIT_COUNT_EN
        chk("hit_count_7", 32'(hit_count), 32'd7);
`else
        chk("hit_count_off", 32'(hit_count), 32'd0);
`endif
      end
      if (f == 2) chk("hit_count_0", 32'(hit_count), 32'd0);
      tick(1);
      drive(1'b0, 14'h0000, 1'b0, 1'b1, 1'b1, 12'h000);
      tick(4);
      for (int p = 0; p < 10; p++) begin
        if (f == 0 && p < 7) drive(1'b1, 14'h0123, 1'b1, 1'b1, 1'b1, 12'h111);
        else if (f == 0)     drive(1'b1, 14'h0124, 1'b1, 1'b1, 1'b1, 12'h222);
        else                 drive(1'b0, 14'h0123, 1'b1, 1'b1, 1'b1, 12'h333);
        tick(1);
      end
      drive(1'b0, 14'h0000, 1'b0, 1'b1, 1'b1, 12'h000);
      tick(3);
    end

    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
